// File: rtl/wide_add_sequencer.sv
// Wide unsigned adder controller: drives one shared SLICE_BITS-wide adder
// LSB slice first, one slice per clock, with a start/busy/done handshake.
module wide_add_sequencer #(
  parameter int unsigned SLICE_BITS = 4,
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned W         = SLICE_BITS * NUM_SLICES
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          sum,
  output logic                  overflow,
  output logic [SLICE_BITS-1:0] add_a,
  output logic [SLICE_BITS-1:0] add_b,
  output logic                  add_carry_in,
  input  logic [SLICE_BITS-1:0] add_sum,
  input  logic                  add_overflow
);

  localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= carry_in;
            sum   <= '0;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum[idx*SLICE_BITS +: SLICE_BITS] <= add_sum;
          carry <= add_overflow;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            overflow <= add_overflow;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The shared adder sees zeros whenever this controller is not calculating.
  always_comb begin
    add_a        = '0;
    add_b        = '0;
    add_carry_in = 1'b0;
    if (state == CALC) begin
      add_a        = a_reg[idx*SLICE_BITS +: SLICE_BITS];
      add_b        = b_reg[idx*SLICE_BITS +: SLICE_BITS];
      add_carry_in = carry;
    end
  end

  assign busy = (state == CALC) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer driving a behavioural
// 4-bit adder slice.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_carry_in;
  logic [3:0]  add_sum;
  logic        add_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared adder_4bit slice.
  assign {add_overflow, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 5'(add_carry_in);

  wide_add_sequencer #(.SLICE_BITS(4), .NUM_SLICES(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .a            (a),
    .b            (b),
    .carry_in     (carry_in),
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .overflow     (overflow),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_carry_in (add_carry_in),
    .add_sum      (add_sum),
    .add_overflow (add_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One operation: start pulsed for one edge, then 8 cycles observed.
  // Sample k=1 is the first negedge after the accepting edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input bit interfere, output int done_n, output int done_at,
                        output int busy_n, output logic [8:0] first_add);
    @(negedge clk);
    a = ta; b = tb; carry_in = tc; start = 1'b1;
    done_n = 0; done_at = 0; busy_n = 0; first_add = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = k; end
      if (k == 1) first_add = {add_carry_in, add_b, add_a};
      start = 1'b0;
      if (interfere && k == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
      end
    end
  endtask

  int          dn, dat, bn, last_done, dones, total_done;
  logic [8:0]  fa;
  logic [15:0] oa [0:40];
  logic [15:0] ob [0:40];
  logic        oc [0:40];
  logic [15:0] ra, rb;
  logic        rc;
  logic [16:0] ref_val;

  initial begin
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_add", 32'({add_carry_in, add_b, add_a}), 32'h0);
    n_rst = 1'b1;

    // 1: carry ripples through every slice
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, dn, dat, bn, fa);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_ovf", 32'(overflow), 32'h1);
    check("t1_done_at", 32'(dat), 32'd5);
    check("t1_done_n", 32'(dn), 32'd1);

    // 2: carry_in used, no carry out
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, dn, dat, bn, fa);
    check("t2_sum", 32'(sum), 32'h5556);
    check("t2_ovf", 32'(overflow), 32'h0);
    check("t2_done_n", 32'(dn), 32'd1);
    check("t2_busy_n", 32'(bn), 32'd5);
    check("t2_slice0_add", 32'(fa), 32'h114);
    check("t2_idle_add", 32'({add_carry_in, add_b, add_a}), 32'h0);

    // 3: start and operand changes while busy are ignored
    run_op(16'h1234, 16'h4321, 1'b1, 1'b1, dn, dat, bn, fa);
    check("t3_sum", 32'(sum), 32'h5556);
    check("t3_done_n", 32'(dn), 32'd1);
    check("t3_busy_n", 32'(bn), 32'd5);

    // 4: reset at idx==2 aborts the operation
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; carry_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_partial_sum", 32'(sum), 32'h0001);
    n_rst = 1'b0;
    #1;
    check("t4_rst_sum", 32'(sum), 32'h0);
    check("t4_rst_ovf", 32'(overflow), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    @(negedge clk); n_rst = 1'b1;
    dones = 0;
    repeat (8) begin @(negedge clk); if (done) dones++; end
    check("t4_no_done", 32'(dones), 32'd0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, dn, dat, bn, fa);
    check("t4_rerun_sum", 32'(sum), 32'h0001);
    check("t4_rerun_ovf", 32'(overflow), 32'h1);
    check("t4_rerun_done", 32'(dn), 32'd1);

    // 5: start held high; operands change every cycle
    for (int i = 0; i <= 40; i++) begin
      oa[i] = 16'($urandom()); ob[i] = 16'($urandom()); oc[i] = 1'($urandom());
    end
    @(negedge clk);
    a = oa[0]; b = ob[0]; carry_in = oc[0]; start = 1'b1;
    dones = 0; last_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        ref_val = {1'b0, oa[n-5]} + {1'b0, ob[n-5]} + 17'(oc[n-5]);
        check("t5_result", 32'({overflow, sum}), 32'(ref_val));
        if (last_done >= 0) check("t5_spacing", 32'(n - last_done), 32'd6);
        else check("t5_first_done", 32'(n), 32'd5);
        last_done = n;
      end
      a = oa[n]; b = ob[n]; carry_in = oc[n];
    end
    check("t5_dones", 32'(dones), 32'd6);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // 6: random operands against a 17-bit reference
    total_done = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom()); rb = 16'($urandom()); rc = 1'($urandom());
      run_op(ra, rb, rc, 1'b0, dn, dat, bn, fa);
      total_done += dn;
      ref_val = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      check("t6_random", 32'({overflow, sum}), 32'(ref_val));
    end
    check("t6_all_done", 32'(total_done), 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
